// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared widths, lane constants and byte-lane merge helper for dmem_responder
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = 4;
    localparam logic [LANES-1:0] WEN_NONE = 4'b0000;

    // Per byte lane: take new_word where wen is set, otherwise keep old_word.
    function automatic logic [WORD_W-1:0] lane_merge(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [LANES-1:0]  wen
    );
        logic [WORD_W-1:0] merged;
        for (int i = 0; i < LANES; i++) begin
            merged[8*i +: 8] = wen[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// rtl/dmem_wbuf.sv - one-entry posted write buffer with capture/merge/commit and read forwarding
module dmem_wbuf
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cap_idx,
    input  logic [LANES-1:0]  cap_wen,
    input  logic [WORD_W-1:0] cap_data,
    input  logic              hold,
    input  logic [ADDR_W-1:0] rd_idx,
    input  logic [WORD_W-1:0] rd_word,
    output logic [WORD_W-1:0] rd_merged,
    input  logic [ADDR_W-1:0] dbg_idx,
    input  logic [WORD_W-1:0] dbg_word,
    output logic [WORD_W-1:0] dbg_merged,
    output logic              commit_valid,
    output logic [ADDR_W-1:0] commit_idx,
    output logic [LANES-1:0]  commit_wen,
    output logic [WORD_W-1:0] commit_data
);

    logic              wbuf_valid;
    logic [ADDR_W-1:0] wbuf_idx;
    logic [LANES-1:0]  wbuf_wen;
    logic [WORD_W-1:0] wbuf_data;

    logic capture;
    logic same_word;

    // A held (out-of-range) access leaves the buffer exactly as it is.
    assign capture   = (cap_wen != WEN_NONE) && !hold;
    assign same_word = wbuf_valid && (cap_idx == wbuf_idx);

    // Drain to the array unless the next store lands on the same word and simply merges in.
    assign commit_valid = wbuf_valid && !hold && !(capture && same_word);
    assign commit_idx   = wbuf_idx;
    assign commit_wen   = wbuf_wen;
    assign commit_data  = wbuf_data;

    // Forward buffered lanes over stale array contents for both read views.
    assign rd_merged  = (wbuf_valid && rd_idx == wbuf_idx)
                      ? lane_merge(rd_word, wbuf_data, wbuf_wen) : rd_word;
    assign dbg_merged = (wbuf_valid && dbg_idx == wbuf_idx)
                      ? lane_merge(dbg_word, wbuf_data, wbuf_wen) : dbg_word;

    // Buffer state: capture or merge a new store, or empty after an idle-cycle commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbuf_valid <= 1'b0;
            wbuf_idx   <= '0;
            wbuf_wen   <= WEN_NONE;
            wbuf_data  <= '0;
        end else if (!hold) begin
            if (capture) begin
                wbuf_valid <= 1'b1;
                if (same_word) begin
                    wbuf_wen  <= wbuf_wen | cap_wen;
                    wbuf_data <= lane_merge(wbuf_data, cap_data, cap_wen);
                end else begin
                    wbuf_idx  <= cap_idx;
                    wbuf_wen  <= cap_wen;
                    wbuf_data <= cap_data;
                end
            end else begin
                wbuf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data RAM responder; optional range check under DM_RANGE_CHK_EN
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       dm_addr,
    input  logic [3:0]        dm_wen,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_rdata,
    output logic              dm_err
);

    logic [WORD_W-1:0] mem [0:(2**ADDR_W)-1];

    logic [31:0]       offset;
    logic [ADDR_W-1:0] word_idx;
    logic              out_of_range;
    logic [WORD_W-1:0] rd_merged;
    logic              commit_valid;
    logic [ADDR_W-1:0] commit_idx;
    logic [LANES-1:0]  commit_wen;
    logic [WORD_W-1:0] commit_data;

    assign offset   = dm_addr - BASE_ADDR;
    assign word_idx = offset[ADDR_W+1:2];

`ifdef DM_RANGE_CHK_EN
    logic unused_offset;
    assign unused_offset = ^offset[1:0];
    assign out_of_range  = |offset[31:ADDR_W+2];

    // One-cycle error pulse aligned with the zeroed read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_err <= 1'b0;
        end else begin
            dm_err <= out_of_range;
        end
    end
`else
    logic unused_offset;
    assign unused_offset = ^{offset[31:ADDR_W+2], offset[1:0]};
    assign out_of_range  = 1'b0;
    assign dm_err        = 1'b0;
`endif

    dmem_wbuf #(
        .ADDR_W (ADDR_W)
    ) u_wbuf (
        .clk          (clk),
        .rst          (rst),
        .cap_idx      (word_idx),
        .cap_wen      (dm_wen),
        .cap_data     (dm_wdata),
        .hold         (out_of_range),
        .rd_idx       (word_idx),
        .rd_word      (mem[word_idx]),
        .rd_merged    (rd_merged),
        .dbg_idx      (dbg_addr),
        .dbg_word     (mem[dbg_addr]),
        .dbg_merged   (dbg_rdata),
        .commit_valid (commit_valid),
        .commit_idx   (commit_idx),
        .commit_wen   (commit_wen),
        .commit_data  (commit_data)
    );

    // Array write port: only buffered stores ever reach the RAM, byte lane by byte lane.
    always_ff @(posedge clk) begin
        if (commit_valid) begin
            for (int i = 0; i < LANES; i++) begin
                if (commit_wen[i]) begin
                    mem[commit_idx][8*i +: 8] <= commit_data[8*i +: 8];
                end
            end
        end
    end

    // Registered read of the pre-write merged word; zero for a rejected access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_rdata <= '0;
        end else if (out_of_range) begin
            dm_rdata <= '0;
        end else begin
            dm_rdata <= rd_merged;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wen;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_rdata;
    logic        dm_err;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(
        .ADDR_W    (8),
        .BASE_ADDR (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dm_addr   (dm_addr),
        .dm_wen    (dm_wen),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata),
        .dm_err    (dm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present one access for a full cycle, then step just past the edge.
    task drive(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        dm_addr  = a;
        dm_wen   = w;
        dm_wdata = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        dm_addr  = 32'h0;
        dm_wen   = 4'b0000;
        dm_wdata = 32'h0;
        dbg_addr = 8'h0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", dm_rdata, 32'h0);
        check("reset_err", {31'b0, dm_err}, 32'h0);
        rst = 1'b0;
        #1;
        check("release_rdata_held", dm_rdata, 32'h0);

        // Store then immediate load of the same word is forwarded.
        drive(32'h10, 4'b1111, 32'hDEADBEEF);
        drive(32'h10, 4'b0000, 32'h0);
        check("fwd_after_sw", dm_rdata, 32'hDEADBEEF);
        drive(32'h10, 4'b0000, 32'h0);
        check("array_after_commit", dm_rdata, 32'hDEADBEEF);
        dbg_addr = 8'd4;
        #1;
        check("dbg_word4", dbg_rdata, 32'hDEADBEEF);

        // Back-to-back stores to different words both land.
        drive(32'h30, 4'b1111, 32'hA5A5A5A5);
        drive(32'h34, 4'b1111, 32'h5A5A5A5A);
        drive(32'h30, 4'b0000, 32'h0);
        check("b2b_first", dm_rdata, 32'hA5A5A5A5);
        drive(32'h34, 4'b0000, 32'h0);
        check("b2b_second", dm_rdata, 32'h5A5A5A5A);

        // Byte store merged onto a still-buffered word store.
        drive(32'h20, 4'b1111, 32'h11223344);
        drive(32'h20, 4'b0100, 32'h00AA0000);
        drive(32'h20, 4'b0000, 32'h0);
        check("merge_fwd", dm_rdata, 32'h11AA3344);
        drive(32'h20, 4'b0000, 32'h0);
        check("merge_array", dm_rdata, 32'h11AA3344);

        // Top-lane store keeps lower bytes; debug port sees it buffered and committed.
        drive(32'h24, 4'b1111, 32'h01020304);
        drive(32'h24, 4'b1000, 32'h77000000);
        dbg_addr = 8'd9;
        #1;
        check("dbg_buffered", dbg_rdata, 32'h77020304);
        repeat (3) drive(32'h24, 4'b0000, 32'h0);
        check("sb_read", dm_rdata, 32'h77020304);
        check("dbg_committed", dbg_rdata, 32'h77020304);

        // Pending store discarded by a mid-cycle reset; write cycle returns pre-write data.
        drive(32'h10, 4'b1111, 32'hCAFEF00D);
        check("read_before_write", dm_rdata, 32'hDEADBEEF);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_rdata", dm_rdata, 32'h0);
        dbg_addr = 8'd4;
        #1;
        check("rst_drops_wbuf", dbg_rdata, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(32'h10, 4'b0000, 32'h0);
        check("word_unchanged", dm_rdata, 32'hDEADBEEF);

        // Last in-range word.
        drive(32'h3FC, 4'b1111, 32'h3F3F3F3F);
        drive(32'h3FC, 4'b0000, 32'h0);
        check("top_word", dm_rdata, 32'h3F3F3F3F);
        check("top_word_err", {31'b0, dm_err}, 32'h0);

        drive(32'h0, 4'b1111, 32'h0BADF00D);
        drive(32'h0, 4'b0000, 32'h0);
        check("word0", dm_rdata, 32'h0BADF00D);
`ifdef DM_RANGE_CHK_EN
        drive(32'h400, 4'b1111, 32'h12345678);
        check("oor_rdata", dm_rdata, 32'h0);
        check("oor_err", {31'b0, dm_err}, 32'h1);
        drive(32'h0, 4'b0000, 32'h0);
        check("oor_err_cleared", {31'b0, dm_err}, 32'h0);
        check("oor_no_write", dm_rdata, 32'h0BADF00D);
`else
        drive(32'h400, 4'b1111, 32'h12345678);
        check("alias_err", {31'b0, dm_err}, 32'h0);
        drive(32'h0, 4'b0000, 32'h0);
        check("alias_write", dm_rdata, 32'h12345678);
        dbg_addr = 8'd0;
        #1;
        check("alias_dbg", dbg_rdata, 32'h12345678);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
